sobel_edge_filter: RTL and testbench

// - Streaming 3x3 Sobel edge detector; sits directly downstream of the grayscale converter and consumes its 12-bit gray pixels.
// - Buffers two image rows, forms a 3x3 window, computes |Gx|+|Gy| saturated to 12 bits, one result per input pixel.
// - Output feeds the display/frame-store path in raster order; the frame size is fixed by parameters.

---
 rtl/sobel_pkg.sv | 23 ++
 rtl/sobel_line_buffer.sv | 48 ++++
 rtl/sobel_edge_filter.sv | 251 +++++++++++++++++++++++++
 tb/tb_sobel_edge_filter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, widths and helpers for the Sobel edge filter
package sobel_pkg;

    localparam int PIX_W  = 12;
    localparam int GRAD_W = 15;
    localparam logic [PIX_W-1:0] MAG_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } sobel_state_t;

    typedef logic [PIX_W-1:0] win_t [3][3];

    // Magnitude of a signed gradient. The most negative code is unreachable
    // because the largest gradient is 4*(2^PIX_W-1).
    function automatic logic [GRAD_W-1:0] grad_abs(input logic signed [GRAD_W-1:0] g);
        return g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - two cascaded one-row delays feeding the 3x3 window
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer only)
//   en         : advance one pixel
//   din        : pixel entering the current row
//   tap1       : pixel one row earlier at the same column
//   tap2       : pixel two rows earlier at the same column
module sobel_line_buffer #(
    parameter int IMG_W = 640,
    parameter int PIX_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] tap1,
    output logic [PIX_W-1:0] tap2
);
    import sobel_pkg::*;

    localparam int PW = $clog2(IMG_W);

    logic [PIX_W-1:0] row1_mem [IMG_W];
    logic [PIX_W-1:0] row2_mem [IMG_W];
    logic [PW-1:0]    ptr;

    // Circular buffers: the slot at ptr was written exactly IMG_W enables
    // ago, so reading before overwriting yields the one-row delay.
    assign tap1 = row1_mem[ptr];
    assign tap2 = row2_mem[ptr];

    always_ff @(posedge clk) begin
        if (en) begin
            row1_mem[ptr] <= din;
            row2_mem[ptr] <= row1_mem[ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PW'(IMG_W - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/sobel_edge_filter.sv
// rtl/sobel_edge_filter.sv - streaming 3x3 Sobel edge magnitude, one result per pixel
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   gray_in    : gray pixel in raster order
//   in_valid   : gray_in valid; beat accepted on in_valid && in_ready
//   in_sof     : accepted beat is pixel (0,0) of a new frame
//   in_ready   : low while the tail of a frame is flushed out
//   edge_out   : |Gx|+|Gy| saturated to PIX_W bits, 0 on the image border
//   out_valid  : single-cycle pulse per result, no backpressure
//   out_eof    : marks the result of the last pixel of the frame
module sobel_edge_filter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] gray_in,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [PIX_W-1:0] edge_out,
    output logic             out_valid,
    output logic             out_eof
);
    import sobel_pkg::*;

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int FW    = $clog2(IMG_W + 1);

    localparam logic [PIX_W-1:0]  SAT     = '1;
    localparam logic [GRAD_W-1:0] SAT_EXT = GRAD_W'(SAT);

    sobel_state_t state, state_n;

    logic [CW-1:0] in_cnt;      // index of the next pixel to be accepted
    logic [FW-1:0] flush_cnt;
    logic [XW-1:0] cx;          // centre column of the window being completed
    logic [YW-1:0] cy;          // centre row of the window being completed

    logic accept, restart, adv, produce;
    logic border, last_pix;

    logic [PIX_W-1:0] din, tap1, tap2;
    logic [PIX_W-1:0] win [3][3];   // [row][col], row 0 = oldest row, col 2 = newest column

    logic v1, b1, e1;
    logic v2, b2, e2;
    logic signed [GRAD_W-1:0] w_s [3][3];
    logic signed [GRAD_W-1:0] gx_c, gy_c, gx, gy;
    logic [GRAD_W-1:0]        mag;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        in_ready = (state != FLUSH);
        accept   = in_valid && in_ready;
        adv      = accept;
        restart  = 1'b0;
        produce  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    restart = 1'b1;
                    state_n = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if (in_sof) begin
                        restart = 1'b1;
                    end else if (in_cnt == CW'(IMG_W + 1)) begin
                        produce = 1'b1;
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (in_sof) begin
                        restart = 1'b1;
                        state_n = FILL;
                    end else begin
                        produce = 1'b1;
                        if (in_cnt == CW'(TOTAL - 1)) begin
                            state_n = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                // Zero-padded beats push the last IMG_W+1 centres through.
                adv     = 1'b1;
                produce = 1'b1;
                if (flush_cnt == FW'(IMG_W)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt    <= '0;
            flush_cnt <= '0;
            cx        <= '0;
            cy        <= '0;
        end else begin
            if (restart) begin
                in_cnt <= CW'(1);
            end else if (accept) begin
                in_cnt <= in_cnt + CW'(1);
            end

            flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;

            if (restart) begin
                cx <= '0;
                cy <= '0;
            end else if (produce) begin
                if (cx == XW'(IMG_W - 1)) begin
                    cx <= '0;
                    cy <= (cy == YW'(IMG_H - 1)) ? '0 : cy + YW'(1);
                end else begin
                    cx <= cx + XW'(1);
                end
            end
        end
    end

    assign border   = (cx == '0) || (cx == XW'(IMG_W - 1)) ||
                      (cy == '0) || (cy == YW'(IMG_H - 1));
    assign last_pix = (cx == XW'(IMG_W - 1)) && (cy == YW'(IMG_H - 1));

    // ------------------------------------------------------------------
    // Stage 1: row delays and window shift
    // ------------------------------------------------------------------
    assign din = (state == FLUSH) ? '0 : gray_in;

    sobel_line_buffer #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W)
    ) u_line_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .din   (din),
        .tap1  (tap1),
        .tap2  (tap2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
            v1 <= 1'b0;
            b1 <= 1'b0;
            e1 <= 1'b0;
        end else begin
            if (adv) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= tap2;
                win[1][2] <= tap1;
                win[2][2] <= din;
            end
            v1 <= produce;
            b1 <= border;
            e1 <= produce && last_pix;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: gradients
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_s[r][c] = $signed({{(GRAD_W - PIX_W){1'b0}}, win[r][c]});
            end
        end
        gx_c = (w_s[0][2] + (w_s[1][2] <<< 1) + w_s[2][2])
             - (w_s[0][0] + (w_s[1][0] <<< 1) + w_s[2][0]);
        gy_c = (w_s[2][0] + (w_s[2][1] <<< 1) + w_s[2][2])
             - (w_s[0][0] + (w_s[0][1] <<< 1) + w_s[0][2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx <= '0;
            gy <= '0;
            v2 <= 1'b0;
            b2 <= 1'b0;
            e2 <= 1'b0;
        end else begin
            if (v1) begin
                gx <= gx_c;
                gy <= gy_c;
            end
            v2 <= v1;
            b2 <= b1;
            e2 <= e1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: magnitude, saturation, border blanking
    // ------------------------------------------------------------------
    assign mag = grad_abs(gx) + grad_abs(gy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_out  <= '0;
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            if (v2) begin
                if (b2) begin
                    edge_out <= '0;
                end else if (mag > SAT_EXT) begin
                    edge_out <= SAT;
                end else begin
                    edge_out <= mag[PIX_W-1:0];
                end
            end
            out_valid <= v2;
            out_eof   <= v2 && e2;
        end
    end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// tb/tb_sobel_edge_filter.sv - self-checking bench for sobel_edge_filter
module tb_sobel_edge_filter;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;
    localparam int FLAT = 0;
    localparam int STEP = 1;
    localparam int RAMP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] gray_in = '0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_ready;
    logic [11:0] edge_out;
    logic        out_valid;
    logic        out_eof;

    sobel_edge_filter #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .edge_out  (edge_out),
        .out_valid (out_valid),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int exp_val[$];
    int exp_eof[$];
    int got_q[$];
    int seq_a[$];
    bit first_seen = 1'b0;
    int first_out_cyc = -1;
    int busy_run = 0;
    int last_busy = 0;

    task automatic chk(input string name, input int got, input int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    function automatic int pix(input int mode, input int x, input int y);
        if (mode == FLAT) return 12'h800;
        if (mode == STEP) return (x < 4) ? 0 : 12'hFFF;
        return x * 4;
    endfunction

    function automatic int exp_edge(input int mode, input int x, input int y);
        int gx, gy, mag;
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
        gx = (pix(mode, x+1, y-1) + 2*pix(mode, x+1, y) + pix(mode, x+1, y+1))
           - (pix(mode, x-1, y-1) + 2*pix(mode, x-1, y) + pix(mode, x-1, y+1));
        gy = (pix(mode, x-1, y+1) + 2*pix(mode, x, y+1) + pix(mode, x+1, y+1))
           - (pix(mode, x-1, y-1) + 2*pix(mode, x, y-1) + pix(mode, x+1, y-1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > 4095) ? 4095 : mag;
    endfunction

    task automatic push_frame(input int mode, input int count);
        for (int c = 0; c < count; c++) begin
            exp_val.push_back(exp_edge(mode, c % W, c / W));
            exp_eof.push_back((c == N - 1) ? 1 : 0);
        end
    endtask

    task automatic send(input int p, input bit sof, input int gap, output int acc, output int waited);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        gray_in  = p[11:0];
        in_sof   = sof;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int mode, input bit gaps, input int npix,
                              output int acc9, output int wait0);
        int a, w, gap;
        acc9  = -1;
        wait0 = -1;
        for (int n = 0; n < npix; n++) begin
            gap = 0;
            if (gaps && $urandom_range(0, 9) < 3) gap = $urandom_range(1, 3);
            send(pix(mode, n % W, n / W), (n == 0), gap, a, w);
            if (n == 9) acc9 = a;
            if (n == 0) wait0 = w;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_val.size() > 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_empty", exp_val.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_edge_out"},  edge_out, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_eof"},   out_eof, 0);
        chk({tag, "_in_ready"},  in_ready, 1);
    endtask

    // Single compare process: every result pulse is matched against the model queue.
    always @(negedge clk) begin
        int v, e;
        if (rst_n) begin
            if (out_valid) begin
                got_q.push_back(edge_out);
                if (!first_seen) begin
                    first_seen    = 1'b1;
                    first_out_cyc = cyc;
                end
                if (exp_val.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    v = exp_val.pop_front();
                    e = exp_eof.pop_front();
                    chk("edge_out", edge_out, v);
                    chk("out_eof", out_eof, e);
                end
            end else begin
                chk("eof_without_valid", out_eof, 0);
            end
            if (!in_ready) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy = busy_run;
                busy_run  = 0;
            end
        end
    end

    initial begin
        int acc9, w0, a2, w1, diff;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Pin the model against hand-computed values.
        chk("pin_step_x3", exp_edge(STEP, 3, 2), 4095);
        chk("pin_step_x4", exp_edge(STEP, 4, 1), 4095);
        chk("pin_step_x2", exp_edge(STEP, 2, 2), 0);
        chk("pin_ramp",    exp_edge(RAMP, 3, 3), 32);
        chk("pin_flat",    exp_edge(FLAT, 2, 2), 0);
        chk("pin_border",  exp_edge(RAMP, 0, 2), 0);

        // Flat frame then step frame back-to-back.
        got_q.delete();
        push_frame(FLAT, N);
        send_frame(FLAT, 1'b0, N, acc9, w0);
        chk("first_pixel_wait", w0, 0);
        push_frame(STEP, N);
        send_frame(STEP, 1'b0, N, a2, w1);
        chk("flush_wait_cycles", w1, W + 1);
        chk("busy_run_length", last_busy, W + 1);
        chk("first_out_latency", first_out_cyc - acc9, 3);
        drain();
        chk("flat_step_count", got_q.size(), 2 * N);
        chk("step_pix_3_2", (got_q.size() > N + 19) ? got_q[N + 19] : -1, 4095);
        chk("step_pix_4_4", (got_q.size() > N + 36) ? got_q[N + 36] : -1, 4095);

        // Ramp without gaps.
        got_q.delete();
        push_frame(RAMP, N);
        send_frame(RAMP, 1'b0, N, acc9, w0);
        drain();
        seq_a = got_q;
        chk("ramp_pix_3_3", (got_q.size() > 27) ? got_q[27] : -1, 32);
        chk("ramp_pix_0_3", (got_q.size() > 24) ? got_q[24] : -1, 0);

        // Ramp with random gaps must reproduce the same sequence.
        got_q.delete();
        push_frame(RAMP, N);
        send_frame(RAMP, 1'b1, N, acc9, w0);
        drain();
        chk("gap_seq_len", got_q.size(), seq_a.size());
        diff = 0;
        for (int i = 0; i < N; i++) begin
            if (i >= got_q.size() || i >= seq_a.size() || got_q[i] != seq_a[i]) diff++;
        end
        chk("gap_seq_diff", diff, 0);

        // Abort at pixel 20: the partial frame's 11 centres still emerge, then a full flat frame.
        got_q.delete();
        push_frame(RAMP, 11);
        send_frame(RAMP, 1'b0, 20, acc9, w0);
        push_frame(FLAT, N);
        send_frame(FLAT, 1'b0, N, acc9, w0);
        drain();
        chk("abort_total_pulses", got_q.size(), 11 + N);

        // Reset mid-frame, then a full step frame.
        push_frame(RAMP, 11);
        send_frame(RAMP, 1'b0, 20, acc9, w0);
        rst_n = 1'b0;
        exp_val.delete();
        exp_eof.delete();
        @(negedge clk);
        check_reset_values("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        got_q.delete();
        push_frame(STEP, N);
        send_frame(STEP, 1'b0, N, acc9, w0);
        chk("post_reset_wait", w0, 0);
        drain();
        chk("post_reset_count", got_q.size(), N);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
